// File: rtl/port_share_pkg.sv
// Shared types and defaults for the port-sharing sequencer.
package port_share_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } ps_state_e;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_CAPTURE_LAT = 2;

  // Low bit of requester idx's word inside a flattened operand bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after pointer, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  // Scan from the farthest offset back to the pointer so the nearest candidate wins.
  always_comb begin
    int cand;
    cand    = 0;
    win_idx = '0;
    any_req = |req;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(pointer) + off) % NUM_REQ;
      if (req[cand]) win_idx = IDX_W'(cand);
    end
    win_oh = any_req ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/port_share_sequencer.sv
// Time-shares one tx-triggered two-word input port between NUM_REQ requesters.
// Each transfer: grant + latch operands, pulse port_tx, wait out the capture
// latency, then ack the owner and re-arm the port with a port_rst pulse.
module port_share_sequencer
  import port_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CAPTURE_LAT = DEFAULT_CAPTURE_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      port_rst,
  output logic                      port_tx,
  output logic [DATA_W-1:0]         port_in1,
  output logic [DATA_W-1:0]         port_in2,
  output logic                      ctx_valid,
  output logic [2*DATA_W-1:0]       last_ctx,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (CAPTURE_LAT > 1) ? $clog2(CAPTURE_LAT) : 1;

  ps_state_e            state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [IDX_W-1:0]     win_idx, win_idx_nxt;
  logic [CNT_W-1:0]     wait_cnt, wait_cnt_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, ack_nxt;
  logic                 port_rst_nxt, port_tx_nxt, ctx_valid_nxt, busy_nxt;
  logic [DATA_W-1:0]    port_in1_nxt, port_in2_nxt;
  logic [2*DATA_W-1:0]  last_ctx_nxt;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .any_req (arb_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    win_idx_nxt   = win_idx;
    wait_cnt_nxt  = wait_cnt;
    gnt_nxt       = gnt;
    ack_nxt       = '0;
    port_rst_nxt  = 1'b0;
    port_tx_nxt   = 1'b0;
    port_in1_nxt  = port_in1;
    port_in2_nxt  = port_in2;
    ctx_valid_nxt = 1'b0;
    last_ctx_nxt  = last_ctx;
    case (state)
      IDLE: begin
        if (arb_any) begin
          gnt_nxt      = arb_oh;
          win_idx_nxt  = arb_idx;
          port_in1_nxt = req_in1[slice_lo(int'(arb_idx), DATA_W) +: DATA_W];
          port_in2_nxt = req_in2[slice_lo(int'(arb_idx), DATA_W) +: DATA_W];
          port_tx_nxt  = 1'b1;
          state_nxt    = LAUNCH;
        end
      end
      LAUNCH: begin
        wait_cnt_nxt = CNT_W'(CAPTURE_LAT - 1);
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = DONE;
        else                wait_cnt_nxt = wait_cnt - CNT_W'(1);
      end
      DONE: begin
        ack_nxt       = gnt;
        ctx_valid_nxt = 1'b1;
        port_rst_nxt  = 1'b1;
        last_ctx_nxt  = {port_in1, port_in2};
        ptr_nxt       = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        gnt_nxt       = '0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Output, pointer and counter registers; reset holds the port in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      win_idx   <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      ack       <= '0;
      port_rst  <= 1'b1;
      port_tx   <= 1'b0;
      port_in1  <= '0;
      port_in2  <= '0;
      ctx_valid <= 1'b0;
      last_ctx  <= '0;
      busy      <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      win_idx   <= win_idx_nxt;
      wait_cnt  <= wait_cnt_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      port_rst  <= port_rst_nxt;
      port_tx   <= port_tx_nxt;
      port_in1  <= port_in1_nxt;
      port_in2  <= port_in2_nxt;
      ctx_valid <= ctx_valid_nxt;
      last_ctx  <= last_ctx_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_port_share_sequencer.sv
// Bench for port_share_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_port_share_sequencer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CL = 2;
  localparam int L  = 2 + CL;   // edges from the sampling edge to the ack edge

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_in1, req_in2;
  logic [N-1:0]     gnt, ack;
  logic             port_rst, port_tx, ctx_valid, busy;
  logic [W-1:0]     port_in1, port_in2;
  logic [2*W-1:0]   last_ctx;

  port_share_sequencer #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .CAPTURE_LAT (CL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .gnt       (gnt),
    .ack       (ack),
    .port_rst  (port_rst),
    .port_tx   (port_tx),
    .port_in1  (port_in1),
    .port_in2  (port_in2),
    .ctx_valid (ctx_valid),
    .last_ctx  (last_ctx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: an in-flight transfer is just "cycles since grant".
  int             m_phase = -1;
  int             m_ptr   = 0;
  int             m_win   = 0;
  logic [N-1:0]   e_gnt = '0, e_ack = '0;
  logic           e_prst = 1'b1, e_tx = 1'b0, e_cv = 1'b0, e_busy = 1'b0;
  logic [W-1:0]   e_in1 = '0, e_in2 = '0;
  logic [2*W-1:0] e_ctx = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    e_ack  = '0;
    e_tx   = 1'b0;
    e_cv   = 1'b0;
    e_prst = 1'b0;
    if (rst) begin
      m_phase = -1;
      m_ptr   = 0;
      e_gnt   = '0;
      e_prst  = 1'b1;
      e_in1   = '0;
      e_in2   = '0;
      e_ctx   = '0;
      e_busy  = 1'b0;
    end else if (m_phase < 0) begin
      if (|req) begin
        m_win = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_win < 0 && req[c]) m_win = c;
        end
        e_gnt   = N'(1) << m_win;
        e_in1   = req_in1[m_win*W +: W];
        e_in2   = req_in2[m_win*W +: W];
        e_tx    = 1'b1;
        e_busy  = 1'b1;
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == L) begin
        e_ack   = e_gnt;
        e_cv    = 1'b1;
        e_prst  = 1'b1;
        e_ctx   = {e_in1, e_in2};
        m_ptr   = (m_win + 1) % N;
        e_gnt   = '0;
        e_busy  = 1'b0;
        m_phase = -1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt",       gnt,       e_gnt);
    chk("ack",       ack,       e_ack);
    chk("port_rst",  port_rst,  e_prst);
    chk("port_tx",   port_tx,   e_tx);
    chk("port_in1",  port_in1,  e_in1);
    chk("port_in2",  port_in2,  e_in2);
    chk("ctx_valid", ctx_valid, e_cv);
    chk("last_ctx",  last_ctx,  e_ctx);
    chk("busy",      busy,      e_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int acks;
    int ng;
    rst     = 1'b1;
    req     = '0;
    req_in1 = '0;
    req_in2 = '0;

    // Reset state and release.
    do_reset();
    chk("reset_prst", port_rst, 1'b1);
    chk("reset_gnt",  gnt, '0);
    step();
    chk("release_prst", port_rst, 1'b0);

    // Single request from requester 1.
    req_in1[1*W +: W] = 16'hA5A5;
    req_in2[1*W +: W] = 16'h3C3C;
    req = 4'b0010;
    step();
    chk("single_gnt", gnt, 4'b0010);
    chk("single_tx",  port_tx, 1'b1);
    chk("single_in1", port_in1, 16'hA5A5);
    chk("single_in2", port_in2, 16'h3C3C);
    step();
    chk("single_tx_low", port_tx, 1'b0);
    step();
    step();
    step();
    chk("single_ack",  ack, 4'b0010);
    chk("single_ctx",  last_ctx, 32'hA5A53C3C);
    chk("single_cv",   ctx_valid, 1'b1);
    chk("single_prst", port_rst, 1'b1);
    req = '0;
    step();

    // All four continuously requesting from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_in1[i*W +: W] = W'(16'h1000 + i);
      req_in2[i*W +: W] = W'(16'hB000 + 16 * i);
    end
    req  = 4'b1111;
    acks = 0;
    ng   = 0;
    for (int c = 0; c < 21; c++) begin
      step();
      if (|ack) acks++;
      if (port_tx) begin
        for (int i = 0; i < N; i++)
          if (gnt[i]) chk("rr_order", i, ng % N);
        ng++;
      end
    end
    chk("rr_acks",   acks, 4);
    chk("rr_grants", ng, 5);
    req = '0;
    for (int c = 0; c < 6; c++) step();

    // Fairness: req0 held, req2 joins during req0's transfer.
    req = 4'b0001;
    step();
    chk("fair_first", gnt, 4'b0001);
    req = 4'b0101;
    for (int c = 0; c < L; c++) step();
    chk("fair_ack0", ack, 4'b0001);
    step();
    chk("fair_next", gnt, 4'b0100);
    for (int c = 0; c < L; c++) step();
    chk("fair_ack2", ack, 4'b0100);
    req = 4'b0001;
    step();
    chk("fair_back", gnt, 4'b0001);
    req = '0;
    for (int c = 0; c < L + 1; c++) step();

    // Reset while waiting on the port.
    req_in1[3*W +: W] = 16'hCAFE;
    req_in2[3*W +: W] = 16'hBEEF;
    req = 4'b1000;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rstmid_ack",  ack, '0);
    chk("rstmid_cv",   ctx_valid, 1'b0);
    chk("rstmid_prst", port_rst, 1'b1);
    chk("rstmid_gnt",  gnt, '0);
    rst = 1'b0;
    for (int c = 0; c < L + 1; c++) step();
    chk("rstmid_ack3", ack, 4'b1000);
    chk("rstmid_ctx",  last_ctx, 32'hCAFEBEEF);
    req = '0;
    step();

    // Requester 1 drops req and changes operands right after grant.
    req_in1[1*W +: W] = 16'h1234;
    req_in2[1*W +: W] = 16'h5678;
    req = 4'b0010;
    step();
    req = '0;
    req_in1[1*W +: W] = 16'hFFFF;
    req_in2[1*W +: W] = 16'h0000;
    for (int c = 0; c < L; c++) step();
    chk("drop_ack", ack, 4'b0010);
    chk("drop_ctx", last_ctx, 32'h12345678);
    step();

    // Idle soak.
    for (int c = 0; c < 50; c++) step();

    // Random traffic under the requester contract, with occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            req_in1[i*W +: W] = W'($urandom);
            req_in2[i*W +: W] = W'($urandom);
          end
        end else if (e_ack[i] && $urandom_range(1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(15) == 0) begin
        int s;
        s = int'($urandom_range(N - 1));
        req_in1[s*W +: W] = W'($urandom);
      end
      rst = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 8; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
